// File: rtl/serial_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// serial_ripple_subtractor
//   Bit-serial ripple-borrow subtractor computing d = a - b - bin, one bit per
//   clock, LSB first. Operands are taken in with a valid/ready handshake. The
//   result is offered with a second valid/ready handshake, so the block can sit
//   between an operand source and a result sink.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a, b, bin valid
//   in_ready   out  1      block can accept operands (IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      sink accepts result
//   d          out  WIDTH  difference, unsigned mod 2^WIDTH
//   bout       out  1      borrow-out (a < b + bin, unsigned)
//   ovf        out  1      two's-complement overflow
//
// States
//   state  | meaning
//   IDLE   | waiting for operands, in_ready=1
//   RUN    | one bit of the difference computed per edge
//   DONE   | result held, out_valid=1 until out_ready
// -----------------------------------------------------------------------------
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             borrow_q, borrow_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    // Single full-subtractor cell, applied to the bit selected by idx_q.
    logic a_bit, b_bit, ab_xor, diff_bit, borrow_nxt;

    always_comb begin
        a_bit      = a_q[idx_q];
        b_bit      = b_q[idx_q];
        ab_xor     = a_bit ^ b_bit;
        diff_bit   = ab_xor ^ borrow_q;
        borrow_nxt = (~a_bit & b_bit) | (~ab_xor & borrow_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        d_d      = d_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                d_d[idx_q] = diff_bit;
                borrow_d   = borrow_nxt;
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    bout_d  = borrow_nxt;
                    // Overflow only when operand signs differ and the result
                    // sign disagrees with the minuend; diff_bit is the MSB here.
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_bit ^ a_q[WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake flags decode the state register only, never the inputs.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule
